// File: rtl/usb_tx_arbiter.sv
// Burst-atomic round-robin arbiter merging the MSC (EP2) and Raw (EP3) IN streams onto the FT601 write path.
// Optional zero-length-packet insertion is enabled by defining USB_TX_ARB_ZLP_EN.
module usb_tx_arbiter #(
  parameter int unsigned MAX_BURST_WORDS = 256,
  parameter logic [1:0]  EP_MSC          = 2'd2,
  parameter logic [1:0]  EP_RAW          = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] msc_tx_data,
  input  logic        msc_tx_valid,
  input  logic        msc_tx_last,
  output logic        msc_tx_ready,
  input  logic [31:0] raw_tx_data,
  input  logic        raw_tx_valid,
  input  logic        raw_tx_last,
  output logic        raw_tx_ready,
  output logic [31:0] ft_tx_data,
  output logic        ft_tx_valid,
  output logic        ft_tx_last,
  output logic [1:0]  ft_tx_ep,
  output logic        ft_tx_zlp,
  input  logic        ft_tx_ready,
  output logic [7:0]  arb_state,
  output logic [15:0] msc_burst_count,
  output logic [15:0] raw_burst_count
);

  localparam int unsigned     CNT_W   = (MAX_BURST_WORDS > 1) ? $clog2(MAX_BURST_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSC  = 2'd1,
    ST_RAW  = 2'd2,
    ST_ZLP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;    // 1: Raw was served last, 0: MSC
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [15:0]      msc_cnt_q, msc_cnt_d;
  logic [15:0]      raw_cnt_q, raw_cnt_d;

  logic             src_is_raw;
  logic [31:0]      src_data;
  logic             src_valid;
  logic             src_last;
  logic             at_cap;
  logic             burst_end;

  assign src_is_raw = (state_q == ST_RAW);
  assign src_data   = src_is_raw ? raw_tx_data  : msc_tx_data;
  assign src_valid  = src_is_raw ? raw_tx_valid : msc_tx_valid;
  assign src_last   = src_is_raw ? raw_tx_last  : msc_tx_last;
  assign at_cap     = (burst_cnt_q == CNT_CAP);
  assign burst_end  = src_last || at_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= '0;
      msc_cnt_q   <= '0;
      raw_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      msc_cnt_q   <= msc_cnt_d;
      raw_cnt_q   <= raw_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    burst_cnt_d  = burst_cnt_q;
    msc_cnt_d    = msc_cnt_q;
    raw_cnt_d    = raw_cnt_q;
    ft_tx_data   = '0;
    ft_tx_valid  = 1'b0;
    ft_tx_last   = 1'b0;
    ft_tx_ep     = '0;
    ft_tx_zlp    = 1'b0;
    msc_tx_ready = 1'b0;
    raw_tx_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie, the source that was not served last wins.
        if (msc_tx_valid && (!raw_tx_valid || rr_last_q)) begin
          state_d = ST_MSC;
        end else if (raw_tx_valid) begin
          state_d = ST_RAW;
        end
      end

      ST_MSC, ST_RAW: begin
        ft_tx_data  = src_data;
        ft_tx_valid = src_valid;
        ft_tx_last  = burst_end;
        ft_tx_ep    = src_is_raw ? EP_RAW : EP_MSC;
        if (src_is_raw) begin
          raw_tx_ready = ft_tx_ready;
        end else begin
          msc_tx_ready = ft_tx_ready;
        end

        if (src_valid && ft_tx_ready) begin
          if (burst_end) begin
            burst_cnt_d = '0;
            rr_last_d   = src_is_raw;
            if (src_is_raw) begin
              raw_cnt_d = raw_cnt_q + 16'd1;
            end else begin
              msc_cnt_d = msc_cnt_q + 16'd1;
            end
            state_d = ST_IDLE;
`ifdef USB_TX_ARB_ZLP_EN
            // A packet ending exactly on the FT601 packet size needs a ZLP terminator.
            if (src_last && at_cap) begin
              state_d = ST_ZLP;
            end
`endif
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef USB_TX_ARB_ZLP_EN
      ST_ZLP: begin
        ft_tx_zlp = 1'b1;
        ft_tx_ep  = rr_last_q ? EP_RAW : EP_MSC;
        if (ft_tx_ready) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  assign arb_state       = {6'b0, state_q};
  assign msc_burst_count = msc_cnt_q;
  assign raw_burst_count = raw_cnt_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: randomized traffic against a burst-level round-robin model.
// Define USB_TX_ARB_ZLP_EN for both files to check zero-length-packet insertion.
module tb_usb_tx_arbiter;

  localparam int MAXW = 256;
  localparam logic [1:0] EPM = 2'd2;
  localparam logic [1:0] EPR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] msc_tx_data = '0;
  logic        msc_tx_valid = 1'b0;
  logic        msc_tx_last = 1'b0;
  logic        msc_tx_ready;
  logic [31:0] raw_tx_data = '0;
  logic        raw_tx_valid = 1'b0;
  logic        raw_tx_last = 1'b0;
  logic        raw_tx_ready;
  logic [31:0] ft_tx_data;
  logic        ft_tx_valid;
  logic        ft_tx_last;
  logic [1:0]  ft_tx_ep;
  logic        ft_tx_zlp;
  logic        ft_tx_ready = 1'b0;
  logic [7:0]  arb_state;
  logic [15:0] msc_burst_count;
  logic [15:0] raw_burst_count;

  usb_tx_arbiter #(.MAX_BURST_WORDS(MAXW), .EP_MSC(EPM), .EP_RAW(EPR)) dut (
    .clk(clk), .rst_n(rst_n),
    .msc_tx_data(msc_tx_data), .msc_tx_valid(msc_tx_valid), .msc_tx_last(msc_tx_last),
    .msc_tx_ready(msc_tx_ready),
    .raw_tx_data(raw_tx_data), .raw_tx_valid(raw_tx_valid), .raw_tx_last(raw_tx_last),
    .raw_tx_ready(raw_tx_ready),
    .ft_tx_data(ft_tx_data), .ft_tx_valid(ft_tx_valid), .ft_tx_last(ft_tx_last),
    .ft_tx_ep(ft_tx_ep), .ft_tx_zlp(ft_tx_zlp), .ft_tx_ready(ft_tx_ready),
    .arb_state(arb_state), .msc_burst_count(msc_burst_count), .raw_burst_count(raw_burst_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic l;} src_word_t;
  typedef struct packed {logic [31:0] d; logic [1:0] ep; logic l; logic z;} exp_t;

  src_word_t msc_src[$];
  src_word_t raw_src[$];
  exp_t      exp_q[$];

  int checks = 0;
  int failures = 0;
  int model_rr = 1;          // 0: MSC served last, 1: Raw served last
  int model_msc_cnt = 0;
  int model_raw_cnt = 0;
  int zlp_seen = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic add_packet(input int src, input int n);
    src_word_t w;
    for (int i = 0; i < n; i++) begin
      w.d = $urandom;
      w.l = (i == n - 1);
      if (src == 0) msc_src.push_back(w);
      else raw_src.push_back(w);
    end
  endtask

  // Expected output stream: packets split into bursts of at most MAXW words,
  // bursts granted round-robin whenever both sources have data waiting.
  function automatic void build_expected();
    int mi = 0;
    int ri = 0;
    int src;
    int n;
    bit done;
    src_word_t w;
    exp_t e;
    exp_q.delete();
    while (mi < msc_src.size() || ri < raw_src.size()) begin
      if (mi < msc_src.size() && ri < raw_src.size()) src = (model_rr == 1) ? 0 : 1;
      else src = (mi < msc_src.size()) ? 0 : 1;
      n = 0;
      done = 0;
      w = '0;
      while (!done) begin
        if (src == 0) begin w = msc_src[mi]; mi++; end
        else begin w = raw_src[ri]; ri++; end
        n++;
        e.d = w.d;
        e.ep = (src == 0) ? EPM : EPR;
        e.l = w.l || (n == MAXW);
        e.z = 1'b0;
        exp_q.push_back(e);
        done = e.l;
      end
      model_rr = src;
      if (src == 0) model_msc_cnt = (model_msc_cnt + 1) % 65536;
      else model_raw_cnt = (model_raw_cnt + 1) % 65536;
`ifdef USB_TX_ARB_ZLP_EN
      if (w.l && n == MAXW) begin
        e.d = '0;
        e.ep = (src == 0) ? EPM : EPR;
        e.l = 1'b0;
        e.z = 1'b1;
        exp_q.push_back(e);
      end
`endif
    end
  endfunction

  // ready_pct < 0 selects ft_tx_ready toggling 1,0,1,0...
  task automatic run_traffic(input int ready_pct, input int max_cycles, output int cycles);
    int cyc = 0;
    int nwords = 0;
    logic prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic [1:0] pe = '0;
    logic pl = 1'b0;
    logic tog = 1'b1;
    exp_t e;
    build_expected();
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      msc_tx_valid = (msc_src.size() > 0);
      msc_tx_data  = msc_tx_valid ? msc_src[0].d : 32'h0;
      msc_tx_last  = msc_tx_valid ? msc_src[0].l : 1'b0;
      raw_tx_valid = (raw_src.size() > 0);
      raw_tx_data  = raw_tx_valid ? raw_src[0].d : 32'h0;
      raw_tx_last  = raw_tx_valid ? raw_src[0].l : 1'b0;
      if (ready_pct < 0) begin
        ft_tx_ready = tog;
        tog = ~tog;
      end else begin
        ft_tx_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      checks++;
      if (msc_tx_ready && raw_tx_ready) begin
        failures++;
        $display("FAIL ready_exclusive: got msc_ready=1 raw_ready=1, required at most one");
      end
      if (ft_tx_valid) begin
        checks++;
        if ((ft_tx_ep == EPM && (msc_tx_ready !== ft_tx_ready || raw_tx_ready !== 1'b0)) ||
            (ft_tx_ep == EPR && (raw_tx_ready !== ft_tx_ready || msc_tx_ready !== 1'b0))) begin
          failures++;
          $display("FAIL source_ready: ep=%0d got msc_ready=%b raw_ready=%b, required granted ready=%b other=0",
                   ft_tx_ep, msc_tx_ready, raw_tx_ready, ft_tx_ready);
        end
      end
      if (prev_stall && ft_tx_valid) begin
        checks++;
        if (ft_tx_data !== pd || ft_tx_ep !== pe || ft_tx_last !== pl) begin
          failures++;
          $display("FAIL stall_hold: got data=%h ep=%0d last=%b, required data=%h ep=%0d last=%b",
                   ft_tx_data, ft_tx_ep, ft_tx_last, pd, pe, pl);
        end
      end
      if (ft_tx_valid && ft_tx_ready) begin
        checks++;
        nwords++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_word: got data=%h ep=%0d, required no word", ft_tx_data, ft_tx_ep);
        end else begin
          e = exp_q.pop_front();
          if (e.z || ft_tx_data !== e.d || ft_tx_ep !== e.ep || ft_tx_last !== e.l) begin
            failures++;
            $display("FAIL word: got data=%h ep=%0d last=%b, required data=%h ep=%0d last=%b zlp=%b",
                     ft_tx_data, ft_tx_ep, ft_tx_last, e.d, e.ep, e.l, e.z);
          end
        end
        if (ft_tx_last) begin
          $display("burst ep=%0d words=%0d", ft_tx_ep, nwords);
          nwords = 0;
        end
      end
      if (ft_tx_zlp) begin
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].z) begin
          failures++;
          $display("FAIL unexpected_zlp: got zlp=1 ep=%0d, required no zlp", ft_tx_ep);
        end else if (ft_tx_ep !== exp_q[0].ep || ft_tx_valid !== 1'b0) begin
          failures++;
          $display("FAIL zlp_fields: got ep=%0d valid=%b, required ep=%0d valid=0",
                   ft_tx_ep, ft_tx_valid, exp_q[0].ep);
        end
        if (ft_tx_ready && exp_q.size() > 0 && exp_q[0].z) begin
          void'(exp_q.pop_front());
          zlp_seen++;
          $display("zlp ep=%0d", ft_tx_ep);
        end
      end
      if (msc_tx_valid && msc_tx_ready) void'(msc_src.pop_front());
      if (raw_tx_valid && raw_tx_ready) void'(raw_src.pop_front());
      prev_stall = ft_tx_valid && !ft_tx_ready;
      pd = ft_tx_data;
      pe = ft_tx_ep;
      pl = ft_tx_last;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL traffic_timeout: got %0d words outstanding after %0d cycles, required 0",
               exp_q.size(), cyc);
      exp_q.delete();
      msc_src.delete();
      raw_src.delete();
    end
    @(negedge clk);
    msc_tx_valid = 1'b0;
    raw_tx_valid = 1'b0;
    msc_tx_last = 1'b0;
    raw_tx_last = 1'b0;
    ft_tx_ready = 1'b0;
    cycles = cyc;
  endtask

  task automatic check_idle_counts(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (arb_state !== 8'd0 || msc_burst_count !== 16'(model_msc_cnt) ||
        raw_burst_count !== 16'(model_raw_cnt)) begin
      failures++;
      $display("FAIL %s_end: got state=%0d msc_cnt=%0d raw_cnt=%0d, required state=0 msc_cnt=%0d raw_cnt=%0d",
               name, arb_state, msc_burst_count, raw_burst_count, model_msc_cnt, model_raw_cnt);
    end
  endtask

  task automatic apply_reset();
    msc_tx_valid = 1'b0;
    raw_tx_valid = 1'b0;
    msc_tx_last = 1'b0;
    raw_tx_last = 1'b0;
    ft_tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_rr = 1;
    model_msc_cnt = 0;
    model_raw_cnt = 0;
    msc_src.delete();
    raw_src.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    msc_tx_valid = 1'b1;
    raw_tx_valid = 1'b1;
    ft_tx_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (arb_state !== 8'd0 || msc_tx_ready !== 1'b0 || raw_tx_ready !== 1'b0 || ft_tx_valid !== 1'b0 ||
        ft_tx_zlp !== 1'b0 || ft_tx_ep !== 2'd0 || ft_tx_data !== 32'd0 || ft_tx_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got state=%0d mr=%b rr=%b v=%b z=%b ep=%0d d=%h l=%b, required all 0",
               arb_state, msc_tx_ready, raw_tx_ready, ft_tx_valid, ft_tx_zlp, ft_tx_ep, ft_tx_data, ft_tx_last);
    end
    apply_reset();
    #1;
    checks++;
    if (msc_burst_count !== 16'd0 || raw_burst_count !== 16'd0 || arb_state !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts: got msc=%0d raw=%0d state=%0d, required 0 0 0",
               msc_burst_count, raw_burst_count, arb_state);
    end
  endtask

  task automatic test_both_valid();
    int cyc;
    add_packet(0, 4);
    add_packet(1, 4);
    run_traffic(100, 100, cyc);
    checks++;
    if (cyc != 10) begin
      failures++;
      $display("FAIL both_valid_cycles: got %0d cycles, required 10", cyc);
    end
    check_idle_counts("both_valid");
  endtask

  task automatic test_single_msc();
    int cyc;
    add_packet(0, 13);
    @(negedge clk);
    msc_tx_valid = 1'b1;
    msc_tx_data = msc_src[0].d;
    msc_tx_last = msc_src[0].l;
    ft_tx_ready = 1'b1;
    #1;
    checks++;
    if (ft_tx_valid !== 1'b0 || msc_tx_ready !== 1'b0 || arb_state !== 8'd0) begin
      failures++;
      $display("FAIL arb_latency: got valid=%b ready=%b state=%0d, required 0 0 0",
               ft_tx_valid, msc_tx_ready, arb_state);
    end
    run_traffic(100, 100, cyc);
    checks++;
    if (cyc != 13) begin
      failures++;
      $display("FAIL single_msc_cycles: got %0d cycles, required 13", cyc);
    end
    check_idle_counts("single_msc");
  endtask

  task automatic test_split();
    int cyc;
    logic [15:0] raw_before;
    raw_before = raw_burst_count;
    add_packet(1, 600);
    add_packet(0, 2);
    run_traffic(100, 2000, cyc);
    check_idle_counts("split");
    checks++;
    if (raw_burst_count !== raw_before + 16'd3) begin
      failures++;
      $display("FAIL split_raw_bursts: got %0d, required %0d", raw_burst_count, raw_before + 16'd3);
    end
  endtask

  task automatic test_stall();
    int cyc;
    add_packet(0, 20);
    run_traffic(-1, 200, cyc);
    check_idle_counts("stall");
  endtask

  task automatic test_zlp();
    int cyc;
    int zlp_required;
`ifdef USB_TX_ARB_ZLP_EN
    zlp_required = 1;
`else
    zlp_required = 0;
`endif
    zlp_seen = 0;
    add_packet(0, 256);
    add_packet(0, 255);
    run_traffic(70, 3000, cyc);
    check_idle_counts("zlp");
    checks++;
    if (zlp_seen != zlp_required) begin
      failures++;
      $display("FAIL zlp_count: got %0d, required %0d", zlp_seen, zlp_required);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < int'($urandom_range(3, 1)); p++) add_packet(0, int'($urandom_range(400, 1)));
      for (int p = 0; p < int'($urandom_range(3, 1)); p++) add_packet(1, int'($urandom_range(400, 1)));
      run_traffic(int'($urandom_range(100, 40)), 20000, cyc);
      check_idle_counts("random");
    end
  endtask

  task automatic test_async_reset();
    int acc = 0;
    int cyc = 0;
    ft_tx_ready = 1'b1;
    raw_tx_last = 1'b0;
    while (acc < 99 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      raw_tx_valid = 1'b1;
      raw_tx_data = $urandom;
      #1;
      if (raw_tx_ready && ft_tx_valid) acc++;
    end
    checks++;
    if (acc < 99) begin
      failures++;
      $display("FAIL async_rst_setup: got %0d raw words, required 99", acc);
    end
    @(negedge clk);
    raw_tx_data = $urandom;
    #1;
    checks++;
    if (ft_tx_valid !== 1'b1 || arb_state !== 8'd2) begin
      failures++;
      $display("FAIL async_rst_word100: got valid=%b state=%0d, required 1 2", ft_tx_valid, arb_state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (arb_state !== 8'd0 || raw_tx_ready !== 1'b0 || ft_tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: got state=%0d raw_ready=%b valid=%b, required 0 0 0",
               arb_state, raw_tx_ready, ft_tx_valid);
    end
    msc_tx_valid = 1'b1;
    msc_tx_data = $urandom;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (arb_state !== 8'd1 || ft_tx_ep !== EPM || raw_tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_tie: got state=%0d ep=%0d raw_ready=%b, required 1 2 0",
               arb_state, ft_tx_ep, raw_tx_ready);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_both_valid();
    test_single_msc();
    test_split();
    test_stall();
    test_zlp();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
